// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM between the fetch (I) and load/store (D) ports, D>I priority.
// Define ARB_STARVE_GUARD_EN to compile in the fetch starvation guard (MAX_WAIT denied cycles).
module mem_port_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [31:0]       i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [31:0]       d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic {IDLE, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  state_t state_reg;
  owner_t owner_reg;
  logic   i_ack_reg;
  logic   d_ack_reg;

  logic   i_cand;
  logic   d_cand;
  logic   pick_i;
  logic   pick_d;

  // Byte-offset bits and address bits above the RAM are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                              d_addr[31:ADDR_W+2], d_addr[1:0]};

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  logic [CNT_W-1:0] wait_reg;
  logic             starve_hit;
  assign starve_hit = (wait_reg == CNT_W'(MAX_WAIT));
`else
  localparam int unused_max_wait = MAX_WAIT;
`endif

  // The port being acked this cycle is retiring its address, so it cannot re-issue yet.
  always_comb begin
    i_cand = i_req && !(state_reg == RESP && owner_reg == OWN_I);
    d_cand = d_req && !(state_reg == RESP && owner_reg == OWN_D);
`ifdef ARB_STARVE_GUARD_EN
    pick_i = i_cand && (!d_cand || starve_hit);
`else
    pick_i = i_cand && !d_cand;
`endif
    pick_d = d_cand && !pick_i;
  end

  // RAM strobes follow the winner combinationally; held at zero while in reset.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (reset) begin
      if (pick_d) begin
        mem_en    = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr[ADDR_W+1:2];
        mem_wdata = d_wdata;
      end else if (pick_i) begin
        mem_en    = 1'b1;
        mem_addr  = i_addr[ADDR_W+1:2];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      owner_reg <= OWN_NONE;
      i_ack_reg <= 1'b0;
      d_ack_reg <= 1'b0;
    end else begin
      i_ack_reg <= pick_i;
      d_ack_reg <= pick_d;
      if (pick_i || pick_d) begin
        state_reg <= RESP;
        owner_reg <= pick_d ? OWN_D : OWN_I;
      end else begin
        state_reg <= IDLE;
        owner_reg <= OWN_NONE;
      end
    end
  end

`ifdef ARB_STARVE_GUARD_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_reg <= '0;
    end else if (pick_i) begin
      wait_reg <= '0;
    end else if (i_req && !starve_hit) begin
      wait_reg <= wait_reg + 1'b1;
    end
  end
`endif

  assign i_ack   = i_ack_reg;
  assign d_ack   = d_ack_reg;
  assign i_rdata = i_ack_reg ? mem_rdata : 32'h0;
  assign d_rdata = d_ack_reg ? mem_rdata : 32'h0;

endmodule
